pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Next-PC controller that owns the fetch program counter register for the dynamic pipeline CPU. It arbitrates every source that can redirect fetch: sequential increment, branch/jump from ID, exception entry, and eret. It defers redirects that arrive while the hazard unit stalls fetch, and it produces the IF flush request. It sits between the hazard/branch/CP0 logic and instruction memory.

Parameters:
RESET_PC, 32'h00400000, PC value loaded on reset.
EXC_VECTOR, 32'h00400004, exception handler entry address.
PC_INC, 32'd4, sequential increment.

Ports:
clk  input  1  clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
stall_i  input  1  hazard unit fetch stall; holds the PC.
br_valid_i  input  1  branch taken, resolved in ID.
br_target_i  input  32  branch target.
jmp_valid_i  input  1  j/jal/jr/jalr redirect from ID.
jmp_target_i  input  32  jump target.
exc_req_i  input  1  exception request from CP0/MEM.
exc_cause_i  input  5  ExcCode of the request.
exc_pc_i  input  32  PC of the faulting instruction.
eret_i  input  1  eret executing.
epc_i  input  32  CP0 EPC, used as the eret return target.
pc_o  output  32  current fetch PC, to imem.
flush_o  output  1  flush the IF/ID register. Combinational.
pend_o  output  1  deferred redirect held.
trap_o  output  1  in TRAP drain cycle.
epc_o  output  32  captured faulting PC.
cause_o  output  5  captured ExcCode.

Behaviour:
- Reset: all regs update asynchronously on posedge rst.
  - pc_o=RESET_PC; epc_o=0; cause_o=0.
  - State=RUN, so pend_o=0 and trap_o=0.
  - Pending target register=0.
- All inputs are sampled at posedge clk. pc_o changes only at that edge. There is no reset-release bubble.
- Target alignment: bits [1:0] of every target are forced to 0. pc_o[1:0] is always 2'b00.
- Sequential update: pc+PC_INC, modulo 2^32. 32'hFFFFFFFC wraps to 0.
- Priority per cycle, highest first:
  - exc_req_i
  - eret_i
  - br_valid_i
  - jmp_valid_i
  - pending target
  - sequential
- Both br and jmp valid is a pipeline bug; br wins, with no error flag.
- FSM states:
  - RUN: no redirect pending.
  - PEND: redirect captured during stall, waiting to apply.
  - TRAP: one drain cycle after exception entry.
- RUN:
  - exc_req_i: next pc=EXC_VECTOR; epc_o<=exc_pc_i; cause_o<=exc_cause_i; flush_o=1; go TRAP. Takes effect even when stall_i=1.
  - eret_i: next pc=epc_i, aligned; flush_o=1; stay RUN. Takes effect even when stalled.
  - br/jmp valid with stall_i=0: next pc=target; flush_o=1.
  - br/jmp valid with stall_i=1: pc holds; target captured into the pending register; flush_o=0; go PEND.
  - Otherwise: pc advances if !stall_i, else holds.
- PEND:
  - exc_req_i or eret_i: handled as in RUN; the pending target is discarded.
  - New br/jmp: overwrites the pending target. Newest wins.
  - stall_i=0: next pc=pending target (or the same-cycle new br/jmp target); flush_o=1; go RUN.
  - stall_i=1: pc holds.
- TRAP, lasting exactly one cycle:
  - exc_req_i, eret_i, br_valid_i and jmp_valid_i are ignored.
  - flush_o=1.
  - pc advances if !stall_i, else holds.
  - Always returns to RUN.
- flush_o is 0 in all other cases.
- epc_o and cause_o change only on exception entry.
- Reset mid-operation: immediate return to reset values; any pending target is lost.

Decomposition:
- Shared package, cpu_pkg:
  - RESET_PC and EXC_VECTOR constants.
  - PC_INC constant.
  - FSM state enum {RUN, PEND, TRAP}, 2 bits.
  - ExcCode width (5).
- Sub-module pc_next_mux: purely combinational priority selection of next pc, flush and capture enables from the state and inputs.
- Top level holds the PC, pending, EPC/cause and state registers.

Test Plan:
- Reset at 0, release, 3 clocks, no stimulus -> pc_o: 00400000, 00400004, 00400008, 0040000C; flush_o=0 throughout.
- At pc=00400010, br_valid=1, target=00400100, stall=0 -> flush_o=1 that cycle; next pc_o=00400100.
- stall=1 for 3 cycles with jmp_valid=1 (target 00400200) in cycle 1:
  - pc holds and pend_o=1.
  - On stall release: flush_o=1, pc_o=00400200, pend_o=0.
- exc_req=1, cause=5'd12, exc_pc=00400020, same cycle as br_valid=1 while stalled:
  - pc_o=00400004, epc_o=00400020, cause_o=12, trap_o=1 for one cycle.
  - A br_valid presented during TRAP is ignored.
- eret_i=1, epc_i=00400023 -> pc_o=00400020, flush_o=1.
- pc forced to FFFFFFFC by jump, no stall -> next pc_o=00000000.
- rst asserted mid-cycle while in PEND -> pc_o=00400000 immediately and pend_o=0; pending target never applied.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants and types.
// Used by the fetch PC sequencer and its next-PC mux.
package cpu_pkg;

  localparam logic [31:0] RESET_PC   = 32'h0040_0000;
  localparam logic [31:0] EXC_VECTOR = 32'h0040_0004;
  localparam logic [31:0] PC_INC     = 32'd4;
  localparam int          EXC_W      = 5;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PEND = 2'd1,
    TRAP = 2'd2
  } pc_state_t;

  function automatic logic [31:0] align_pc(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC priority selection for the fetch PC.
// Purely combinational: picks next pc, flush and capture enables.
module pc_next_mux
  import cpu_pkg::*;
#(
  parameter logic [31:0] EXC_VEC = EXC_VECTOR,
  parameter logic [31:0] INC     = PC_INC
) (
  input  pc_state_t   state,
  input  logic [31:0] pc,
  input  logic [31:0] pend_tgt,
  input  logic        stall_i,
  input  logic        br_valid_i,
  input  logic [31:0] br_target_i,
  input  logic        jmp_valid_i,
  input  logic [31:0] jmp_target_i,
  input  logic        exc_req_i,
  input  logic        eret_i,
  input  logic [31:0] epc_i,
  output logic [31:0] next_pc,
  output pc_state_t   next_state,
  output logic        flush,
  output logic        pend_we,
  output logic [31:0] pend_d,
  output logic        exc_we
);

  logic        redir;
  logic [31:0] redir_tgt;
  logic [31:0] seq_pc;

  assign redir     = br_valid_i | jmp_valid_i;
  assign redir_tgt = align_pc(br_valid_i ? br_target_i
                                         : jmp_target_i);
  assign seq_pc    = stall_i ? pc : pc + INC;

  always_comb begin
    next_pc    = pc;
    next_state = state;
    flush      = 1'b0;
    pend_we    = 1'b0;
    pend_d     = redir_tgt;
    exc_we     = 1'b0;
    unique case (state)
      TRAP: begin
        // drain cycle: all redirects ignored
        flush      = 1'b1;
        next_pc    = seq_pc;
        next_state = RUN;
      end
      RUN, PEND: begin
        if (exc_req_i) begin
          next_pc    = align_pc(EXC_VEC);
          exc_we     = 1'b1;
          flush      = 1'b1;
          next_state = TRAP;
        end else if (eret_i) begin
          next_pc    = align_pc(epc_i);
          flush      = 1'b1;
          next_state = RUN;
        end else if (redir) begin
          if (stall_i) begin
            pend_we    = 1'b1;
            next_state = PEND;
          end else begin
            next_pc    = redir_tgt;
            flush      = 1'b1;
            next_state = RUN;
          end
        end else if (state == PEND) begin
          if (!stall_i) begin
            next_pc    = pend_tgt;
            flush      = 1'b1;
            next_state = RUN;
          end
        end else begin
          next_pc = seq_pc;
        end
      end
      default: begin
        next_state = RUN;
      end
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC owner: holds PC, deferred redirect, EPC/cause and FSM.
// Next values come from pc_next_mux.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC_P   = RESET_PC,
  parameter logic [31:0] EXC_VECTOR_P = EXC_VECTOR,
  parameter logic [31:0] PC_INC_P     = PC_INC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             br_valid_i,
  input  logic [31:0]      br_target_i,
  input  logic             jmp_valid_i,
  input  logic [31:0]      jmp_target_i,
  input  logic             exc_req_i,
  input  logic [EXC_W-1:0] exc_cause_i,
  input  logic [31:0]      exc_pc_i,
  input  logic             eret_i,
  input  logic [31:0]      epc_i,
  output logic [31:0]      pc_o,
  output logic             flush_o,
  output logic             pend_o,
  output logic             trap_o,
  output logic [31:0]      epc_o,
  output logic [EXC_W-1:0] cause_o
);

  pc_state_t   state;
  pc_state_t   next_state;
  logic [31:0] pc_q;
  logic [31:0] pend_q;
  logic [31:0] next_pc;
  logic        pend_we;
  logic [31:0] pend_d;
  logic        exc_we;
  logic        flush;

  pc_next_mux #(
    .EXC_VEC (EXC_VECTOR_P),
    .INC     (PC_INC_P)
  ) u_mux (
    .state        (state),
    .pc           (pc_q),
    .pend_tgt     (pend_q),
    .stall_i      (stall_i),
    .br_valid_i   (br_valid_i),
    .br_target_i  (br_target_i),
    .jmp_valid_i  (jmp_valid_i),
    .jmp_target_i (jmp_target_i),
    .exc_req_i    (exc_req_i),
    .eret_i       (eret_i),
    .epc_i        (epc_i),
    .next_pc      (next_pc),
    .next_state   (next_state),
    .flush        (flush),
    .pend_we      (pend_we),
    .pend_d       (pend_d),
    .exc_we       (exc_we)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      pc_q  <= align_pc(RESET_PC_P);
    end else begin
      state <= next_state;
      pc_q  <= next_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
    end else if (pend_we) begin
      pend_q <= pend_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      epc_o   <= '0;
      cause_o <= '0;
    end else if (exc_we) begin
      epc_o   <= exc_pc_i;
      cause_o <= exc_cause_i;
    end
  end

  assign pc_o    = pc_q;
  assign flush_o = flush;
  assign pend_o  = (state == PEND);
  assign trap_o  = (state == TRAP);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer.
// Expected values are hand-computed constants.
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        br_valid_i;
  logic [31:0] br_target_i;
  logic        jmp_valid_i;
  logic [31:0] jmp_target_i;
  logic        exc_req_i;
  logic [4:0]  exc_cause_i;
  logic [31:0] exc_pc_i;
  logic        eret_i;
  logic [31:0] epc_i;
  logic [31:0] pc_o;
  logic        flush_o;
  logic        pend_o;
  logic        trap_o;
  logic [31:0] epc_o;
  logic [4:0]  cause_o;

  int n_vec = 0;
  int n_bad = 0;

  pc_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .stall_i      (stall_i),
    .br_valid_i   (br_valid_i),
    .br_target_i  (br_target_i),
    .jmp_valid_i  (jmp_valid_i),
    .jmp_target_i (jmp_target_i),
    .exc_req_i    (exc_req_i),
    .exc_cause_i  (exc_cause_i),
    .exc_pc_i     (exc_pc_i),
    .eret_i       (eret_i),
    .epc_i        (epc_i),
    .pc_o         (pc_o),
    .flush_o      (flush_o),
    .pend_o       (pend_o),
    .trap_o       (trap_o),
    .epc_o        (epc_o),
    .cause_o      (cause_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall_i     = 1'b0;
    br_valid_i  = 1'b0;
    jmp_valid_i = 1'b0;
    exc_req_i   = 1'b0;
    eret_i      = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    br_target_i  = '0;
    jmp_target_i = '0;
    exc_cause_i  = '0;
    exc_pc_i     = '0;
    epc_i        = '0;
    idle();
    #2;
    chk("rst_pc", pc_o, 32'h0040_0000);
    chk("rst_epc", epc_o, 32'h0);
    chk("rst_cause", {27'd0, cause_o}, 32'h0);
    chk("rst_pend", {31'd0, pend_o}, 32'h0);
    chk("rst_trap", {31'd0, trap_o}, 32'h0);
    tick();
    chk("rst_hold", pc_o, 32'h0040_0000);
    rst = 1'b0;
    #1;
    chk("rel_pc", pc_o, 32'h0040_0000);
    chk("rel_flush", {31'd0, flush_o}, 32'h0);
    tick();
    chk("seq1", pc_o, 32'h0040_0004);
    chk("seq1_fl", {31'd0, flush_o}, 32'h0);
    tick();
    chk("seq2", pc_o, 32'h0040_0008);
    tick();
    chk("seq3", pc_o, 32'h0040_000C);
    tick();
    chk("seq4", pc_o, 32'h0040_0010);

    // branch, no stall
    br_valid_i  = 1'b1;
    br_target_i = 32'h0040_0100;
    #1;
    chk("br_fl", {31'd0, flush_o}, 32'h1);
    tick();
    idle();
    #1;
    chk("br_pc", pc_o, 32'h0040_0100);
    chk("br_fl0", {31'd0, flush_o}, 32'h0);

    // jump deferred by a 3-cycle stall
    stall_i      = 1'b1;
    jmp_valid_i  = 1'b1;
    jmp_target_i = 32'h0040_0200;
    #1;
    chk("st1_fl", {31'd0, flush_o}, 32'h0);
    tick();
    jmp_valid_i = 1'b0;
    chk("st1_pc", pc_o, 32'h0040_0100);
    chk("st1_pend", {31'd0, pend_o}, 32'h1);
    tick();
    chk("st2_pc", pc_o, 32'h0040_0100);
    chk("st2_pend", {31'd0, pend_o}, 32'h1);
    tick();
    chk("st3_pc", pc_o, 32'h0040_0100);
    stall_i = 1'b0;
    #1;
    chk("rel_fl", {31'd0, flush_o}, 32'h1);
    tick();
    chk("rel_pc2", pc_o, 32'h0040_0200);
    chk("rel_pend", {31'd0, pend_o}, 32'h0);

    // exception beats branch while stalled
    stall_i     = 1'b1;
    exc_req_i   = 1'b1;
    exc_cause_i = 5'd12;
    exc_pc_i    = 32'h0040_0020;
    br_valid_i  = 1'b1;
    br_target_i = 32'h0040_0300;
    #1;
    chk("exc_fl", {31'd0, flush_o}, 32'h1);
    tick();
    exc_req_i = 1'b0;
    stall_i   = 1'b0;
    chk("exc_pc", pc_o, 32'h0040_0004);
    chk("exc_epc", epc_o, 32'h0040_0020);
    chk("exc_cause", {27'd0, cause_o}, 32'd12);
    chk("exc_trap", {31'd0, trap_o}, 32'h1);
    #1;
    chk("trap_fl", {31'd0, flush_o}, 32'h1);
    tick();
    br_valid_i = 1'b0;
    chk("trap_pc", pc_o, 32'h0040_0008);
    chk("trap_end", {31'd0, trap_o}, 32'h0);
    chk("trap_pend", {31'd0, pend_o}, 32'h0);

    // eret with misaligned EPC
    eret_i = 1'b1;
    epc_i  = 32'h0040_0023;
    #1;
    chk("eret_fl", {31'd0, flush_o}, 32'h1);
    tick();
    eret_i = 1'b0;
    chk("eret_pc", pc_o, 32'h0040_0020);
    chk("eret_epc", epc_o, 32'h0040_0020);

    // wrap at top of address space
    jmp_valid_i  = 1'b1;
    jmp_target_i = 32'hFFFF_FFFF;
    tick();
    jmp_valid_i = 1'b0;
    chk("top_pc", pc_o, 32'hFFFF_FFFC);
    tick();
    chk("wrap_pc", pc_o, 32'h0000_0000);

    // br and jmp together: br wins
    br_valid_i   = 1'b1;
    br_target_i  = 32'h0000_0040;
    jmp_valid_i  = 1'b1;
    jmp_target_i = 32'h0000_0080;
    tick();
    idle();
    chk("both_pc", pc_o, 32'h0000_0040);

    // reset while a redirect is pending
    stall_i     = 1'b1;
    br_valid_i  = 1'b1;
    br_target_i = 32'h0040_0500;
    tick();
    idle();
    stall_i = 1'b1;
    chk("pr_pend", {31'd0, pend_o}, 32'h1);
    chk("pr_pc", pc_o, 32'h0000_0040);
    #1;
    rst = 1'b1;
    #1;
    chk("mr_pc", pc_o, 32'h0040_0000);
    chk("mr_pend", {31'd0, pend_o}, 32'h0);
    chk("mr_epc", epc_o, 32'h0);
    #1;
    rst     = 1'b0;
    stall_i = 1'b0;
    #1;
    chk("mr_fl", {31'd0, flush_o}, 32'h0);
    tick();
    chk("mr_seq", pc_o, 32'h0040_0004);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
